// File: rtl/iomem_cmd_pkg.sv
// Shared definitions for the iomem command master: command/status codes, FSM states, counter widths.
package iomem_cmd_pkg;

    localparam logic [7:0] CMD_READ   = 8'h52;
    localparam logic [7:0] CMD_WRITE  = 8'h57;
    localparam logic [7:0] CMD_MASKED = 8'h4D;

    localparam logic [7:0] STAT_ACK = 8'h06;
    localparam logic [7:0] STAT_NAK = 8'h15;

    localparam int BYTE_CNT_W = 2;
    localparam logic [BYTE_CNT_W-1:0] BYTE_CNT_LAST = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_STRB = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_BUS  = 3'd4,
        ST_RESP = 3'd5
    } state_t;

endpackage

// File: rtl/iomem_cmd_resp_ser.sv
// Response serialiser: loads a status byte plus an optional 32-bit word and emits 1 or 5 bytes, LSB first.
module iomem_cmd_resp_ser (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [7:0]  status,
    input  logic [31:0] word,
    input  logic        with_word,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    logic [31:0] word_r;
    logic [2:0]  left_r;

    assign done = tx_valid && tx_ready && (left_r == 3'd0);

    // Byte shifter; tx_data only moves on an accepted byte so it stays stable under back-pressure
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            word_r   <= 32'h0000_0000;
            left_r   <= 3'd0;
        end else if (load) begin
            tx_valid <= 1'b1;
            tx_data  <= status;
            word_r   <= word;
            left_r   <= with_word ? 3'd4 : 3'd0;
        end else if (tx_valid && tx_ready) begin
            if (left_r == 3'd0) begin
                tx_valid <= 1'b0;
                tx_data  <= 8'h00;
            end else begin
                tx_data  <= word_r[7:0];
                word_r   <= {8'h00, word_r[31:8]};
                left_r   <= left_r - 3'd1;
            end
        end else begin
            tx_valid <= tx_valid;
            tx_data  <= tx_data;
        end
    end

endmodule

// File: rtl/iomem_cmd_master.sv
// UART-framed command decoder driving one iomem read/write per frame and returning ACK/NAK plus data.
// Optional masked-write command 'M' is enabled by defining IOMEM_CMD_MASKED_WRITE_EN.
module iomem_cmd_master #(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [7:0] CMD_READ       = iomem_cmd_pkg::CMD_READ,
    parameter logic [7:0] CMD_WRITE      = iomem_cmd_pkg::CMD_WRITE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    output logic        busy
);

    import iomem_cmd_pkg::*;

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

    state_t                state_r;
    logic [BYTE_CNT_W-1:0] byte_cnt_r;
    logic [TO_W-1:0]       to_cnt_r;
    logic                  is_write_r;
    logic                  resp_load_r;
    logic [7:0]            resp_status_r;
    logic [31:0]           resp_word_r;
    logic                  resp_long_r;
    logic                  rx_accept_s;
    logic                  ser_done_s;

    assign rx_accept_s = rx_valid && rx_ready;

    // Command FSM: frame decode, single bus cycle with timeout, response hand-off
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            byte_cnt_r    <= {BYTE_CNT_W{1'b0}};
            to_cnt_r      <= {TO_W{1'b0}};
            is_write_r    <= 1'b0;
            resp_load_r   <= 1'b0;
            resp_status_r <= 8'h00;
            resp_word_r   <= 32'h0000_0000;
            resp_long_r   <= 1'b0;
            rx_ready      <= 1'b0;
            busy          <= 1'b0;
            iomem_valid   <= 1'b0;
            iomem_wstrb   <= 4'h0;
            iomem_addr    <= 32'h0000_0000;
            iomem_wdata   <= 32'h0000_0000;
        end else begin
            resp_load_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    rx_ready <= 1'b1;
                    if (rx_accept_s) begin
                        busy       <= 1'b1;
                        byte_cnt_r <= {BYTE_CNT_W{1'b0}};
                        if (rx_data == CMD_READ) begin
                            state_r     <= ST_ADDR;
                            iomem_wstrb <= 4'h0;
                            is_write_r  <= 1'b0;
                        end else if (rx_data == CMD_WRITE) begin
                            state_r     <= ST_ADDR;
                            iomem_wstrb <= 4'hF;
                            is_write_r  <= 1'b1;
`ifdef IOMEM_CMD_MASKED_WRITE_EN
                        end else if (rx_data == CMD_MASKED) begin
                            state_r     <= ST_STRB;
                            is_write_r  <= 1'b1;
`endif
                        end else begin
                            state_r       <= ST_RESP;
                            rx_ready      <= 1'b0;
                            resp_load_r   <= 1'b1;
                            resp_status_r <= STAT_NAK;
                            resp_long_r   <= 1'b0;
                        end
                    end
                end
                ST_STRB: begin
                    if (rx_accept_s) begin
                        iomem_wstrb <= rx_data[3:0];
                        state_r     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (rx_accept_s) begin
                        iomem_addr <= {rx_data, iomem_addr[31:8]};
                        byte_cnt_r <= byte_cnt_r + BYTE_CNT_W'(1'b1);
                        if (byte_cnt_r == BYTE_CNT_LAST) begin
                            if (is_write_r) begin
                                state_r <= ST_DATA;
                            end else begin
                                state_r     <= ST_BUS;
                                rx_ready    <= 1'b0;
                                iomem_valid <= 1'b1;
                                to_cnt_r    <= {TO_W{1'b0}};
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_accept_s) begin
                        iomem_wdata <= {rx_data, iomem_wdata[31:8]};
                        byte_cnt_r  <= byte_cnt_r + BYTE_CNT_W'(1'b1);
                        if (byte_cnt_r == BYTE_CNT_LAST) begin
                            rx_ready <= 1'b0;
                            // An all-zero strobe can only come from a masked write and never reaches the bus
                            if (iomem_wstrb == 4'h0) begin
                                state_r       <= ST_RESP;
                                resp_load_r   <= 1'b1;
                                resp_status_r <= STAT_NAK;
                                resp_long_r   <= 1'b0;
                            end else begin
                                state_r     <= ST_BUS;
                                iomem_valid <= 1'b1;
                                to_cnt_r    <= {TO_W{1'b0}};
                            end
                        end
                    end
                end
                ST_BUS: begin
                    if (iomem_valid && iomem_ready) begin
                        iomem_valid   <= 1'b0;
                        resp_word_r   <= iomem_rdata;
                        state_r       <= ST_RESP;
                        resp_load_r   <= 1'b1;
                        resp_status_r <= STAT_ACK;
                        resp_long_r   <= !is_write_r;
                    end else if (to_cnt_r == TO_LIMIT) begin
                        iomem_valid   <= 1'b0;
                        state_r       <= ST_RESP;
                        resp_load_r   <= 1'b1;
                        resp_status_r <= STAT_NAK;
                        resp_long_r   <= 1'b0;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1'b1);
                    end
                end
                ST_RESP: begin
                    if (ser_done_s) begin
                        state_r  <= ST_IDLE;
                        busy     <= 1'b0;
                        rx_ready <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy        <= 1'b0;
                    rx_ready    <= 1'b0;
                    iomem_valid <= 1'b0;
                end
            endcase
        end
    end

    iomem_cmd_resp_ser u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (resp_load_r),
        .status    (resp_status_r),
        .word      (resp_word_r),
        .with_word (resp_long_r),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (ser_done_s)
    );

endmodule

// File: tb/tb_iomem_cmd_master.sv
// Directed self-checking bench for iomem_cmd_master (TIMEOUT_CYCLES = 16).
`timescale 1ns/1ps
module tb_iomem_cmd_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        iomem_valid;
    logic        iomem_ready = 1'b0;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata = 32'h1234_5678;
    logic        busy;

    iomem_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  txq[$];
    int          vhigh = 0, txn = 0, hold_err = 0, vcnt = 0, rsp_lat = 1;
    logic        prev_valid = 1'b0;
    logic [31:0] cap_addr = 32'h0, cap_wdata = 32'h0;
    logic [3:0]  cap_wstrb = 4'h0;

    // Monitor: collect accepted tx bytes and the bus transaction fields
    always @(posedge clk) begin
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        if (iomem_valid) begin
            vhigh = vhigh + 1;
            if (!prev_valid) begin
                txn = txn + 1;
                cap_addr = iomem_addr; cap_wdata = iomem_wdata; cap_wstrb = iomem_wstrb;
            end else if (iomem_addr !== cap_addr || iomem_wdata !== cap_wdata || iomem_wstrb !== cap_wstrb) begin
                hold_err = hold_err + 1;
            end
        end
        prev_valid = iomem_valid;
    end

    // Responder: raise ready on the rsp_lat-th cycle of valid (0 = never)
    always @(negedge clk) begin
        if (iomem_valid) begin
            vcnt = vcnt + 1;
            iomem_ready = (rsp_lat != 0) && (vcnt == rsp_lat);
        end else begin
            vcnt = 0;
            iomem_ready = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] pack_tx();
        logic [63:0] v = 64'h0;
        foreach (txq[i]) v = {v[55:0], txq[i]};
        return v;
    endfunction

    task automatic clear_mon();
        txq.delete(); vhigh = 0; txn = 0; hold_err = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data = b; rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin @(negedge clk); n++; end
        if (n == 100) begin
            checks++; failures++;
            $display("FAIL rx_handshake: rx_ready stayed %b for byte %h, required 1", rx_ready, b);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [79:0] bytes, input int n);
        for (int i = 0; i < n; i++) send_byte(bytes[79-8*i -: 8]);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, busy, n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({rx_ready, tx_valid, iomem_valid, busy, iomem_wstrb, tx_data, iomem_addr, iomem_wdata} !== 80'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h, required all zero",
                     {rx_ready, tx_valid, iomem_valid, busy, iomem_wstrb, tx_data, iomem_addr, iomem_wdata});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: rx_ready=%b busy=%b, required 1 0", rx_ready, busy);
        end
    endtask

    task automatic test_write();
        clear_mon(); rsp_lat = 1;
        send_frame(80'h57_00_00_00_03_EF_BE_AD_DE_00, 9);
        checks++;
        if (iomem_valid !== 1'b1) begin
            failures++;
            $display("FAIL write_latency: iomem_valid=%b one cycle after last byte, required 1", iomem_valid);
        end
        wait_idle("write");
        checks++;
        if (txn !== 1 || cap_addr !== 32'h0300_0000 || cap_wdata !== 32'hDEAD_BEEF || cap_wstrb !== 4'hF || hold_err !== 0) begin
            failures++;
            $display("FAIL write_bus: txn=%0d addr=%h wdata=%h wstrb=%h hold_err=%0d, required 1 03000000 deadbeef f 0",
                     txn, cap_addr, cap_wdata, cap_wstrb, hold_err);
        end
        checks++;
        if (txq.size() !== 1 || pack_tx() !== 64'h06) begin
            failures++;
            $display("FAIL write_tx: got %h (n=%0d), required 06 (n=1)", pack_tx(), txq.size());
        end
    endtask

    task automatic test_read();
        clear_mon(); rsp_lat = 3;
        send_frame(80'h52_00_00_00_03_00_00_00_00_00, 5);
        wait_idle("read");
        checks++;
        if (txn !== 1 || vhigh !== 3 || cap_wstrb !== 4'h0 || cap_addr !== 32'h0300_0000) begin
            failures++;
            $display("FAIL read_bus: txn=%0d valid_cycles=%0d wstrb=%h addr=%h, required 1 3 0 03000000",
                     txn, vhigh, cap_wstrb, cap_addr);
        end
        checks++;
        if (txq.size() !== 5 || pack_tx() !== 64'h06_7856_3412) begin
            failures++;
            $display("FAIL read_tx: got %h (n=%0d), required 0678563412 (n=5)", pack_tx(), txq.size());
        end
    endtask

    task automatic test_timeout();
        clear_mon(); rsp_lat = 0;
        send_frame(80'h52_10_00_00_00_00_00_00_00_00, 5);
        wait_idle("timeout");
        checks++;
        if (vhigh !== TO || txq.size() !== 1 || pack_tx() !== 64'h15) begin
            failures++;
            $display("FAIL timeout: valid_cycles=%0d tx=%h (n=%0d), required %0d 15 (n=1)", vhigh, pack_tx(), txq.size(), TO);
        end
        clear_mon(); rsp_lat = 1;
        send_frame(80'h57_01_00_00_00_55_AA_00_FF_00, 9);
        wait_idle("after_timeout");
        checks++;
        if (txn !== 1 || cap_addr !== 32'h0000_0001 || cap_wdata !== 32'hFF00_AA55 || pack_tx() !== 64'h06 || txq.size() !== 1) begin
            failures++;
            $display("FAIL after_timeout: txn=%0d addr=%h wdata=%h tx=%h, required 1 00000001 ff00aa55 06",
                     txn, cap_addr, cap_wdata, pack_tx());
        end
    endtask

    task automatic test_unknown();
        clear_mon(); rsp_lat = 1;
        send_byte(8'h41);
        wait_idle("unknown");
        checks++;
        if (txn !== 0 || txq.size() !== 1 || pack_tx() !== 64'h15) begin
            failures++;
            $display("FAIL unknown_cmd: txn=%0d tx=%h (n=%0d), required 0 15 (n=1)", txn, pack_tx(), txq.size());
        end
    endtask

    task automatic test_stall();
        int n = 0;
        int bad = 0;
        clear_mon(); rsp_lat = 1; tx_ready = 1'b0;
        send_frame(80'h52_20_00_00_00_00_00_00_00_00, 5);
        while (!tx_valid && n < 100) begin @(negedge clk); n++; end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== 8'h06) bad++;
        end
        checks++;
        if (bad !== 0 || txq.size() !== 0) begin
            failures++;
            $display("FAIL stall_hold: unstable_cycles=%0d accepted=%0d, required 0 0", bad, txq.size());
        end
        tx_ready = 1'b1;
        wait_idle("stall");
        checks++;
        if (txq.size() !== 5 || pack_tx() !== 64'h06_7856_3412) begin
            failures++;
            $display("FAIL stall_tx: got %h (n=%0d), required 0678563412 (n=5)", pack_tx(), txq.size());
        end
    endtask

    task automatic test_reset_mid_bus();
        clear_mon(); rsp_lat = 0;
        send_frame(80'h52_00_00_00_04_00_00_00_00_00, 5);
        repeat (4) @(negedge clk);
        checks++;
        if (iomem_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre: iomem_valid=%b busy=%b, required 1 1", iomem_valid, busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (iomem_valid !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_async: iomem_valid=%b busy=%b tx_valid=%b, required 0 0 0", iomem_valid, busy, tx_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (txq.size() !== 0 || iomem_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_tx: tx_bytes=%0d iomem_valid=%b, required 0 0", txq.size(), iomem_valid);
        end
        clear_mon(); rsp_lat = 2;
        send_frame(80'h57_08_00_00_00_11_22_33_44_00, 9);
        wait_idle("after_reset");
        checks++;
        if (txn !== 1 || vhigh !== 2 || cap_addr !== 32'h0000_0008 || cap_wdata !== 32'h4433_2211 || pack_tx() !== 64'h06) begin
            failures++;
            $display("FAIL after_reset: txn=%0d valid_cycles=%0d addr=%h wdata=%h tx=%h, required 1 2 00000008 44332211 06",
                     txn, vhigh, cap_addr, cap_wdata, pack_tx());
        end
    endtask

    task automatic test_masked();
        clear_mon(); rsp_lat = 1;
`ifdef IOMEM_CMD_MASKED_WRITE_EN
        send_frame(80'h4D_03_00_00_00_03_AA_BB_CC_DD, 10);
        wait_idle("masked");
        checks++;
        if (txn !== 1 || cap_wstrb !== 4'h3 || cap_addr !== 32'h0300_0000 || cap_wdata !== 32'hDDCC_BBAA || pack_tx() !== 64'h06) begin
            failures++;
            $display("FAIL masked_write: txn=%0d wstrb=%h addr=%h wdata=%h tx=%h, required 1 3 03000000 ddccbbaa 06",
                     txn, cap_wstrb, cap_addr, cap_wdata, pack_tx());
        end
        clear_mon();
        send_frame(80'h4D_F0_00_00_00_03_AA_BB_CC_DD, 10);
        wait_idle("masked_zero");
        checks++;
        if (txn !== 0 || txq.size() !== 1 || pack_tx() !== 64'h15) begin
            failures++;
            $display("FAIL masked_zero: txn=%0d tx=%h (n=%0d), required 0 15 (n=1)", txn, pack_tx(), txq.size());
        end
`else
        send_byte(8'h4D);
        wait_idle("masked_off");
        checks++;
        if (txn !== 0 || txq.size() !== 1 || pack_tx() !== 64'h15) begin
            failures++;
            $display("FAIL masked_off: txn=%0d tx=%h (n=%0d), required 0 15 (n=1)", txn, pack_tx(), txq.size());
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_unknown();
        test_stall();
        test_reset_mid_bus();
        test_masked();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
